shift_pipe: RTL and testbench

- Registered valid/ready pipeline built around the team's existing combinational 8-bit logical left shifter (ports ina[7:0], shift[2:0], out[7:0]; out = ina << shift, zero fill).
- Sits between the operand source and the result consumer. Adds input/output staging, backpressure and flush.
- Flags any request whose shift discards a 1 bit, and keeps a saturating count of such overflows.

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_pipe_shifter.sv | 13 +
 rtl/shift_pipe.sv | 103 ++++++++++
 tb/tb_shift_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and the overflow mask helper for the registered shift pipeline.
// Anything that must agree on widths or on what counts as an overflow imports this package.
package shift_pkg;

  localparam int DATA_W  = 8;
  localparam int SHAMT_W = 3;
  localparam int CNT_W   = 8;

  // Bits of the operand that survive a left shift by amt; anything outside is lost.
  function automatic logic [DATA_W-1:0] ovf_mask(input logic [SHAMT_W-1:0] amt);
    return {DATA_W{1'b1}} >> amt;
  endfunction

endpackage

// File: rtl/shift_pipe_shifter.sv
// Combinational 8-bit logical left shifter (zero fill).
// This is the existing shared block, kept unchanged for the pipeline to wrap.
module shift_pipe_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0]  ina,
  input  logic [SHAMT_W-1:0] shift,
  output logic [DATA_W-1:0]  out
);

  assign out = ina << shift;

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready pipeline around the shared left shifter.
// Adds backpressure, synchronous flush, overflow flagging and a saturating overflow counter.
module shift_pipe #(
  parameter int DATA_W  = 8,
  parameter int SHAMT_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   ovf_cnt,
  input  logic               cnt_clr
);
  import shift_pkg::*;

  // The shifter is hard-wired to 8 bits / 3-bit amount, so refuse any other width.
  if (DATA_W != 8 || SHAMT_W != 3) begin : g_width_check
    $error("shift_pipe: DATA_W must be 8 and SHAMT_W must be 3");
  end

  logic               s1_valid;
  logic [DATA_W-1:0]  s1_data;
  logic [SHAMT_W-1:0] s1_shamt;
  logic               s1_ovf;
  logic               s2_valid;
  logic [DATA_W-1:0]  s2_data;
  logic               s2_ovf;
  logic [DATA_W-1:0]  shifted;
  logic               s2_free;
  logic               s1_adv;
  logic               s1_load;
  logic               out_hs;

  shift_pipe_shifter u_shifter (
    .ina   (s1_data),
    .shift (s1_shamt),
    .out   (shifted)
  );

  assign s1_ovf   = (s1_shamt != '0) & (|(s1_data & ~ovf_mask(s1_shamt)));
  assign s2_free  = ~s2_valid | out_ready;
  assign s1_adv   = s1_valid & s2_free;
  // in_ready follows out_ready combinationally so a full pipe can still stream.
  assign in_ready = (~s1_valid | s1_adv) & ~flush;
  assign s1_load  = in_valid & in_ready;
  assign out_hs   = s2_valid & out_ready;

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_ovf   = s2_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_shamt <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_shamt <= in_shamt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 reloads from S1 whenever it drains or is empty; flush overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= shifted;
      s2_ovf   <= s1_ovf;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (cnt_clr) begin
      ovf_cnt <= '0;
    end else if (out_hs && s2_ovf && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: the driver pushes expected results from an arithmetic
// reference model, and an independent monitor pops and compares them as outputs appear.
module tb_shift_pipe;
  import shift_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [2:0] in_shamt = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_ovf;
  logic [7:0] ovf_cnt;
  logic       cnt_clr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       ovf;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails = 0;
  int   model_cnt = 0;
  bit   rand_ready = 1'b0;

  shift_pipe #(.DATA_W(8), .SHAMT_W(3), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .cnt_clr   (cnt_clr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: multiply by 2^s; whatever lands above bit 7 has been shifted out.
  function automatic exp_t refModel(input int d, input int s);
    int   full;
    exp_t e;
    full   = d * (1 << s);
    e.data = 8'(full % 256);
    e.ovf  = (full > 255);
    return e;
  endfunction

  // Holds the request until accepted; returns one clock later at posedge+1.
  task automatic applyStimulus(input logic [7:0] d, input logic [2:0] s, output int stalls);
    bit done;
    done     = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = s;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sbq.push_back(refModel(int'(d), int'(s)));
        done = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      @(negedge clk);
    end
    checkOutput("drain_queue_empty", sbq.size(), 0);
    checkOutput("drain_out_valid", {31'b0, out_valid}, 0);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: compares the presented result with the queue head every cycle and pops on handshake.
  initial begin : monitor
    bit hs_ovf;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sbq.delete();
        model_cnt = 0;
      end else begin
        checkOutput("ovf_cnt", {24'b0, ovf_cnt}, model_cnt);
        hs_ovf = 1'b0;
        if (out_valid) begin
          if (sbq.size() == 0) begin
            checkOutput("spurious_out_valid", {31'b0, out_valid}, 0);
          end else begin
            checkOutput("out_data", {24'b0, out_data}, {24'b0, sbq[0].data});
            checkOutput("out_ovf", {31'b0, out_ovf}, {31'b0, sbq[0].ovf});
            if (out_ready && !flush) begin
              hs_ovf = sbq[0].ovf;
              void'(sbq.pop_front());
            end
          end
        end
        if (flush) sbq.delete();
        if (cnt_clr) model_cnt = 0;
        else if (hs_ovf && model_cnt < 255) model_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int         st;
    int         saved_cnt;
    logic [7:0] d;
    logic [2:0] s;
    exp_t       e;

    #1 rst_n = 1'b0;
    #11;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 0);
    checkOutput("reset_out_data", {24'b0, out_data}, 0);
    checkOutput("reset_out_ovf", {31'b0, out_ovf}, 0);
    checkOutput("reset_ovf_cnt", {24'b0, ovf_cnt}, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed A5 << 3");
    out_ready = 1'b1;
    applyStimulus(8'hA5, 3'd3, st);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("latency_not_early", {31'b0, out_valid}, 0);
    @(negedge clk);
    checkOutput("latency_valid", {31'b0, out_valid}, 1);
    checkOutput("a5_data", {24'b0, out_data}, 32'h28);
    checkOutput("a5_ovf", {31'b0, out_ovf}, 1);
    @(negedge clk);
    checkOutput("a5_cnt", {24'b0, ovf_cnt}, 1);
    @(posedge clk);
    #1;

    $display("[TB] exhaustive back-to-back stream");
    for (int di = 0; di < 256; di++) begin
      for (int si = 0; si < 8; si++) begin
        applyStimulus(8'(di), 3'(si), st);
        checkOutput("stream_no_stall", st, 0);
      end
    end
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h01, 3'd7, st);
    applyStimulus(8'h03, 3'd1, st);
    in_valid = 1'b1;
    in_data  = 8'h80;
    in_shamt = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready_low", {31'b0, in_ready}, 0);
      checkOutput("bp_out_valid", {31'b0, out_valid}, 1);
      checkOutput("bp_hold_data", {24'b0, out_data}, 32'h80);
      checkOutput("bp_hold_ovf", {31'b0, out_ovf}, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    applyStimulus(8'h80, 3'd0, st);
    in_valid = 1'b0;
    waitDrain();

    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(8'hFF, 3'd1, st);
    applyStimulus(8'hC3, 3'd2, st);
    in_valid  = 1'b1;
    in_data   = 8'h11;
    in_shamt  = 3'd1;
    flush     = 1'b1;
    saved_cnt = model_cnt;
    @(negedge clk);
    checkOutput("flush_in_ready_low", {31'b0, in_ready}, 0);
    checkOutput("flush_pre_out_valid", {31'b0, out_valid}, 1);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_out_valid", {31'b0, out_valid}, 0);
    checkOutput("flush_cnt_kept", {24'b0, ovf_cnt}, saved_cnt);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("flush_nothing_emerges", {31'b0, out_valid}, 0);
    end
    @(posedge clk);
    #1;

    $display("[TB] counter saturation and clear");
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    for (int i = 0; i < 300; i++) applyStimulus(8'hFF, 3'd1, st);
    in_valid = 1'b0;
    waitDrain();
    checkOutput("cnt_saturated", {24'b0, ovf_cnt}, 255);
    out_ready = 1'b0;
    applyStimulus(8'hFF, 3'd1, st);
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    checkOutput("clr_setup_valid", {31'b0, out_valid}, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    cnt_clr   = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    checkOutput("clr_beats_increment", {24'b0, ovf_cnt}, 0);
    @(posedge clk);
    #1;
    waitDrain();

    $display("[TB] async reset mid-stream");
    applyStimulus(8'hFF, 3'd1, st);
    in_valid = 1'b0;
    waitDrain();
    out_ready = 1'b0;
    applyStimulus(8'h12, 3'd1, st);
    applyStimulus(8'h34, 3'd2, st);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", {31'b0, out_valid}, 0);
    checkOutput("arst_out_data", {24'b0, out_data}, 0);
    checkOutput("arst_out_ovf", {31'b0, out_ovf}, 0);
    checkOutput("arst_ovf_cnt", {24'b0, ovf_cnt}, 0);
    checkOutput("arst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    d = 8'($urandom);
    s = 3'($urandom);
    e = refModel(int'(d), int'(s));
    applyStimulus(d, s, st);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_not_early", {31'b0, out_valid}, 0);
    @(negedge clk);
    checkOutput("post_rst_valid", {31'b0, out_valid}, 1);
    checkOutput("post_rst_data", {24'b0, out_data}, {24'b0, e.data});
    @(posedge clk);
    #1;
    waitDrain();

    $display("[TB] random traffic with random backpressure");
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      applyStimulus(8'($urandom), 3'($urandom), st);
    end
    in_valid   = 1'b0;
    rand_ready = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    waitDrain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
